// File: rtl/boot_link_pkg.sv
// Shared definitions for the UART boot/debug link: load FSM states and byte ordering.
package boot_link_pkg;

    // Load FSM state encoding (plain constants for compatibility with older tools).
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_RAISE  = 4'd1;
    localparam logic [3:0] ST_FETCH  = 4'd2;
    localparam logic [3:0] ST_LATCH  = 4'd3;
    localparam logic [3:0] ST_SEND   = 4'd4;
    localparam logic [3:0] ST_WAIT   = 4'd5;
    localparam logic [3:0] ST_NEXT   = 4'd6;
    localparam logic [3:0] ST_GUARD  = 4'd7;
    localparam logic [3:0] ST_FINISH = 4'd8;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Image words go out MSB first; the target's debug words arrive LSB first.
    localparam bit LOAD_MSB_FIRST  = 1'b1;
    localparam bit DEBUG_LSB_FIRST = 1'b1;

endpackage

// File: rtl/uart_boot_host_uart.sv
// 8N1 UART: one transmitter and one receiver sharing a baud divisor (cycles per bit).
module UART (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] baud,
    input  logic        trmt,
    input  logic [7:0]  tx_data,
    output logic        tx_done,
    output logic        TX,
    input  logic        RX,
    input  logic        clr_rx_rdy,
    output logic        rx_rdy,
    output logic [7:0]  rx_data
);

    logic [8:0]  tx_shift_q;
    logic [3:0]  tx_bit_q;
    logic [12:0] tx_baud_q;
    logic        tx_busy_q;
    logic        tx_done_q;

    logic        rx_meta_q, rx_sync_q;
    logic [8:0]  rx_shift_q;
    logic [3:0]  rx_bit_q;
    logic [12:0] rx_baud_q;
    logic        rx_busy_q;
    logic        rx_rdy_q;

    // Transmitter: start bit, 8 data bits LSB first, stop bit; tx_done holds until next trmt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= 9'h1ff;
            tx_bit_q   <= 4'd0;
            tx_baud_q  <= 13'd0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else if (trmt) begin
            tx_shift_q <= {tx_data, 1'b0};
            tx_bit_q   <= 4'd0;
            tx_baud_q  <= 13'd0;
            tx_busy_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_baud_q == baud - 13'd1) begin
                tx_baud_q  <= 13'd0;
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + 13'd1;
            end
        end
    end

    assign TX      = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign tx_done = tx_done_q;

    // Receiver: synchronise RX, sample mid-bit, flag rx_rdy after the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_shift_q <= 9'd0;
            rx_bit_q   <= 4'd0;
            rx_baud_q  <= 13'd0;
            rx_busy_q  <= 1'b0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= baud >> 1;
                    rx_bit_q  <= 4'd0;
                    rx_rdy_q  <= 1'b0;
                end
            end else if (rx_baud_q == 13'd0) begin
                rx_baud_q <= baud - 13'd1;
                if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_rdy_q  <= 1'b1;
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[8:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_baud_q <= rx_baud_q - 13'd1;
            end
        end
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_shift_q[8:1];

endmodule

// File: rtl/uart_boot_host.sv
// Host side of the boot link: streams an image to the target bootloader while holding
// debug high, and reassembles the target's debug byte stream into 32-bit words.
module uart_boot_host
    import boot_link_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter logic [12:0] BAUD   = 13'h1b2,
    parameter int unsigned GUARD  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              debug,
    output logic              TX,
    input  logic              RX,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rx_word,
    output logic              rx_valid
);

    logic [3:0]        state_q;
    logic [ADDR_W:0]   count_q, sent_q, sent_nxt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [15:0]       wait_q;
    logic [1:0]        byte_q;
    logic [31:0]       shreg_q;
    logic              debug_q, done_q;

    logic [31:0] acc_q, rx_word_q;
    logic [1:0]  rx_cnt_q;
    logic        rx_valid_q;

    logic       trmt, tx_done, rx_rdy, clr_rx_rdy;
    logic [7:0] tx_data, rx_data;

    assign sent_nxt = sent_q + {{ADDR_W{1'b0}}, 1'b1};
    assign tx_data  = LOAD_MSB_FIRST ? shreg_q[31:24] : shreg_q[7:0];
    assign trmt     = (state_q == ST_SEND);
    assign rd_en    = (state_q == ST_FETCH);

    // Load FSM: raise debug, stream each word as 4 bytes, guard, then drop debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            sent_q    <= '0;
            rd_addr_q <= '0;
            wait_q    <= 16'd0;
            byte_q    <= 2'd0;
            shreg_q   <= 32'd0;
            debug_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    if (word_count != '0) begin
                        count_q   <= word_count;
                        sent_q    <= '0;
                        rd_addr_q <= '0;
                        wait_q    <= 16'd0;
                        debug_q   <= 1'b1;
                        state_q   <= ST_RAISE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                // Entry cycle plus GUARD wait cycles, so the target clears its address.
                ST_RAISE: if (wait_q == 16'(GUARD)) begin
                    wait_q  <= 16'd0;
                    state_q <= ST_FETCH;
                end else begin
                    wait_q <= wait_q + 16'd1;
                end
                ST_FETCH: state_q <= ST_LATCH;
                ST_LATCH: begin
                    shreg_q <= rd_data;
                    byte_q  <= 2'd0;
                    state_q <= ST_SEND;
                end
                ST_SEND: state_q <= ST_WAIT;
                // tx_done is only looked at here, after trmt has cleared any stale flag.
                ST_WAIT: if (tx_done) begin
                    shreg_q <= LOAD_MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
                    byte_q  <= byte_q + 2'd1;
                    state_q <= (byte_q == 2'(BYTES_PER_WORD - 1)) ? ST_NEXT : ST_SEND;
                end
                ST_NEXT: begin
                    rd_addr_q <= rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    sent_q    <= sent_nxt;
                    wait_q    <= 16'd0;
                    state_q   <= (sent_nxt == count_q) ? ST_GUARD : ST_FETCH;
                end
                ST_GUARD: if (wait_q == 16'(GUARD - 1)) begin
                    debug_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_FINISH;
                end else begin
                    wait_q <= wait_q + 16'd1;
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign clr_rx_rdy = rx_rdy;

    // RX reassembly: collect 4 debug bytes LSB first; start resynchronises the byte count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= 32'd0;
            rx_cnt_q   <= 2'd0;
            rx_word_q  <= 32'd0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (start) begin
                rx_cnt_q <= 2'd0;
            end else if (rx_rdy) begin
                acc_q    <= DEBUG_LSB_FIRST ? {rx_data, acc_q[31:8]} : {acc_q[23:0], rx_data};
                rx_cnt_q <= rx_cnt_q + 2'd1;
                if (rx_cnt_q == 2'd3) begin
                    rx_word_q  <= DEBUG_LSB_FIRST ? {rx_data, acc_q[31:8]}
                                                  : {acc_q[23:0], rx_data};
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    UART u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud       (BAUD),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .TX         (TX),
        .RX         (RX),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data)
    );

    assign rd_addr  = rd_addr_q;
    assign debug    = debug_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);
    assign rx_word  = rx_word_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/uart_boot_host.md
# uart_boot_host

Host-side counterpart of the UART boot/debug link. Streams a program image from a local word-addressed memory to a target's bootloader: it holds the target's `debug` line high for the whole transfer and sends each 32-bit word as 4 bytes, MSB first. It also reassembles the target's debug output stream (4 bytes per word, LSB first) into 32-bit words. It is used in the board test harness and in host-side FPGA images.

## Interface
- `ADDR_W`, default 10: image memory address width; the maximum image size is 2^ADDR_W words.
- `BAUD`, default 13'h1b2: baud divisor passed to `UART`.
- `GUARD`, default 8: idle cycles between the last `tx_done` and `debug` falling.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load. Ignored while `busy`.
- `word_count` in ADDR_W+1: number of words to send. Sampled on `start`.
- `rd_en` out 1: image memory read strobe.
- `rd_addr` out ADDR_W: image memory address.
- `rd_data` in 32: image memory data, valid 1 cycle after `rd_en`.
- `debug` out 1: drives the target's debug/boot-enable pin.
- `TX` out 1: serial line to the target. `RX` in 1: serial line from the target.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse when a load completes.
- `rx_word` out 32: last reassembled debug word. `rx_valid` out 1: one-cycle pulse when `rx_word` updates.

## Operation
- Reset values: `rd_en`=0, `rd_addr`=0, `debug`=0, `TX`=1 (UART idle), `busy`=0, `done`=0, `rx_word`=0, `rx_valid`=0. All FSMs return to IDLE and all counters clear.
- Load FSM states: IDLE, RAISE, FETCH, LATCH, SEND, WAIT, NEXT, GUARD, FINISH.
- IDLE: on `start` with `word_count`!=0, latch the count, clear `rd_addr`, go to RAISE. On `start` with `word_count`==0, pulse `done` next cycle and stay in IDLE; `debug` is never asserted.
- RAISE: set `debug`=1 and wait GUARD cycles so the target clears its address.
- FETCH: assert `rd_en` for 1 cycle.
- LATCH: load `rd_data` into the 32-bit shift register and clear the byte counter.
- SEND: `tx_data` = shreg[31:24]. Pulse `trmt` for 1 cycle, go to WAIT.
- WAIT: wait for `tx_done`, then shift shreg left by 8 and increment the byte counter. If the counter is <4, go to SEND. If it reaches 4, go to NEXT.
- NEXT: `rd_addr`+1. If words sent == count, go to GUARD; otherwise go to FETCH.
- GUARD: wait GUARD cycles with `debug` still 1, so the target finishes its final word commit.
- FINISH: `debug`=0, pulse `done`, return to IDLE.
- The `rd_addr` increment wraps modulo 2^ADDR_W. This is only reachable when `word_count`==2^ADDR_W, which is legal.
- `debug` stays high continuously from RAISE through GUARD. Dropping it mid-image resets the target's address, so that is forbidden.
- RX reassembly runs independently of the load FSM and at all times:
  - On `rx_rdy`: pulse `clr_rx_rdy` and set acc = {rx_data, acc[31:8]}.
  - Increment a 2-bit byte counter. When it wraps 3→0, copy acc into `rx_word` and pulse `rx_valid`, both the next cycle.
- The RX byte counter is cleared by reset and by `start`.
- Reset mid-load: everything aborts immediately, `debug` drops, and the UART transmitter returns to idle. A partially sent word is not resumed.

## Timing
- `start` → `debug` high: 1 cycle.
- `debug` high → first `trmt`: GUARD+3 cycles.
- Per word: 3 cycles plus 4 byte times.
- `tx_done` is sampled only in WAIT, which is entered the cycle after `trmt`. This prevents a stale `tx_done` from skipping a byte.
- Last `tx_done` → `debug` low and `done`: GUARD+2 cycles.
- `rx_valid` follows the 4th `rx_rdy` by 1 cycle.
- Simultaneous `start` and a received byte: the counter clear from `start` takes priority, and the byte is dropped from reassembly.

## Structure
- Shared package `boot_link_pkg`:
  - load FSM state enum;
  - `BYTES_PER_WORD`=4;
  - byte-order constants (load = MSB first, debug = LSB first).
- Sub-module: the existing `UART`, instantiated once with `.baud(BAUD)`.
- The load FSM and the RX reassembler are separate always blocks in this module.

## Test plan
- Load 2 words, 32'h11223344 then 32'hA5A55A5A → TX bytes 11,22,33,44,A5,A5,5A,5A in order; `debug` is high throughout; exactly one `done` pulse.
- `word_count`=0 → `done` 1 cycle after `start`; `debug` and `TX` never toggle.
- Loopback TX→RX of the target's debug stream: bytes EF,BE,AD,DE → `rx_word`=32'hDEADBEEF with one `rx_valid`.
- `start` pulsed during a load → ignored; the byte sequence is unchanged.
- `rst_n` low mid-byte in word 1 → `debug`=0 and `TX`=1 within 1 cycle; a new `start` resends from address 0.
- End-to-end with the target bootloader model: a 16-word image lands at target addresses 0..15 exactly.
